// File: rtl/seq_restoring_divider_if.sv
// seq_restoring_divider_if: start/done handshake bundle for the restoring divider.
//   start, dividend, divisor        : request side (driven by master)
//   busy, done, quotient, remainder,
//   div_by_zero                     : response side (driven by slave)
interface seq_restoring_divider_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/seq_restoring_divider.sv
// seq_restoring_divider: multi-cycle unsigned restoring divider, one quotient
// bit per clock, start/done handshake.
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : slave side of seq_restoring_divider_if (start/operands in,
//          busy/done/quotient/remainder/div_by_zero out, all registered)
module seq_restoring_divider #(
  parameter int WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  seq_restoring_divider_if.slave bus
);
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] d_reg;
  // Restoring keeps R < D after every iteration, so only WIDTH bits need
  // storing; the extra bit exists only in the shifted/trial values.
  logic [WIDTH-1:0] r_reg;
  logic [CW-1:0]    cnt;

  logic             busy_r;
  logic             done_r;
  logic [WIDTH-1:0] quot_r;
  logic [WIDTH-1:0] rem_r;
  logic             dbz_r;

  logic [WIDTH:0]   r_shift;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] r_next;
  logic [WIDTH-1:0] q_next;

  always_comb begin
    r_shift = {r_reg, q_reg[WIDTH-1]};
    trial   = r_shift - {1'b0, d_reg};
    if (!trial[WIDTH]) begin
      r_next = trial[WIDTH-1:0];
      q_next = {q_reg[WIDTH-2:0], 1'b1};
    end else begin
      r_next = r_shift[WIDTH-1:0];
      q_next = {q_reg[WIDTH-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      q_reg  <= '0;
      d_reg  <= '0;
      r_reg  <= '0;
      cnt    <= '0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
      quot_r <= '0;
      rem_r  <= '0;
      dbz_r  <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            q_reg <= bus.dividend;
            d_reg <= bus.divisor;
            r_reg <= '0;
            cnt   <= CW'(WIDTH - 1);
            if (bus.divisor == '0) begin
              // Zero divisor skips the iterations and publishes immediately.
              state  <= DONE;
              busy_r <= 1'b0;
              done_r <= 1'b1;
              quot_r <= '1;
              rem_r  <= bus.dividend;
              dbz_r  <= 1'b1;
            end else begin
              state  <= RUN;
              busy_r <= 1'b1;
              dbz_r  <= 1'b0;
            end
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          q_reg <= q_next;
          r_reg <= r_next;
          if (cnt == '0) begin
            // Results are taken from the final iteration's next values so
            // they are valid in the same cycle done is high.
            state  <= DONE;
            busy_r <= 1'b0;
            done_r <= 1'b1;
            quot_r <= q_next;
            rem_r  <= r_next;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy        = busy_r;
  assign bus.done        = done_r;
  assign bus.quotient    = quot_r;
  assign bus.remainder   = rem_r;
  assign bus.div_by_zero = dbz_r;
endmodule
